// File: rtl/cpu_controller.sv
// Instruction sequencer for the 5-bit-address accumulator CPU: 8-phase cycle per instruction.
// Strobes are combinational from phase, opcode, zero and the halted flag; HLT parks the phase at 4.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e r_phase;
  phase_e w_phase_nxt;
  logic   r_halted;
  logic   w_halted_nxt;
  logic   w_aluop;
  logic   w_skz;
  logic   w_sto;
  logic   w_jmp;

  assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_skz   = (opcode == OP_SKZ);
  assign w_sto   = (opcode == OP_STO);
  assign w_jmp   = (opcode == OP_JMP);
  assign phase   = r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      w_phase_nxt = phase_e'(r_phase + 3'd1);
      case (r_phase)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          // PC steps past the instruction here, even for HLT
          inc_pc = 1'b1;
          if (opcode == OP_HLT) begin
            halt         = 1'b1;
            w_halted_nxt = 1'b1;
            w_phase_nxt  = OP_ADDR;
          end
        end
        OP_FETCH: rd = w_aluop;
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = w_skz & zero;
          ld_pc  = w_jmp;
          data_e = w_sto;
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = w_jmp;
          wr     = w_sto;
          data_e = w_sto;
        end
        default: ;
      endcase
    end
  end

endmodule
